smult_oddtab_pipe: RTL and testbench

- Pipelined, parametrised generator of the odd-multiple operand table (1A,3A,5A,7A,9A,11A,13A,15A) for radix-16 multipliers.
- Successor to the combinational 65-bit multiple generator:
  - any operand width;
  - signed or unsigned operand chosen per transaction;
  - two-stage register pipeline with valid/ready backpressure, flush and a pass-through tag.
- Sits between operand read and the radix-16 partial-product selector.

---
 rtl/smult_pkg.sv | 23 ++
 rtl/adder.sv | 13 +
 rtl/adder_CSA.sv | 17 +
 rtl/smult_oddtab_s1.sv | 44 ++++
 rtl/smult_oddtab_pipe.sv | 149 ++++++++++++++
 tb/tb_smult_oddtab_pipe.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/smult_pkg.sv
// Shared definitions for the radix-16 odd-multiple table generator.
package smult_pkg;

   localparam int unsigned NMULT = 8;
   localparam int unsigned EXT_W = 4;

   typedef enum logic [2:0] {
      MUL_1  = 3'd0,
      MUL_3  = 3'd1,
      MUL_5  = 3'd2,
      MUL_7  = 3'd3,
      MUL_9  = 3'd4,
      MUL_11 = 3'd5,
      MUL_13 = 3'd6,
      MUL_15 = 3'd7
   } mult_idx_e;

   // Extension bits placed above the operand MSB: sign copies or zeros.
   function automatic logic [EXT_W-1:0] oext(input logic msb, input logic sgn);
      return (sgn && msb) ? '1 : '0;
   endfunction

endpackage

// File: rtl/adder.sv
// Carry-propagate adder cell with carry-in, result modulo 2^W.
module adder #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_s
);

   assign o_s = i_a + i_b + {{(W-1){1'b0}}, i_cin};

endmodule

// File: rtl/adder_CSA.sv
// 3:2 carry-save compressor; carry vector is pre-shifted, result modulo 2^W.
module adder_CSA #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_s,
   output logic [W-1:0] o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = {(i_a[W-2:0] & i_b[W-2:0]) |
                 (i_a[W-2:0] & i_c[W-2:0]) |
                 (i_b[W-2:0] & i_c[W-2:0]), 1'b0};

endmodule

// File: rtl/smult_oddtab_s1.sv
// Stage-1 combinational logic: operand extension, direct sums and carry-save pairs.
module smult_oddtab_s1 import smult_pkg::*; #(
   parameter  int unsigned WIDTH = 65,
   localparam int unsigned OW    = WIDTH + EXT_W
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic             i_signed,
   output logic [OW-1:0]    o_a1,
   output logic [OW-1:0]    o_a3,
   output logic [OW-1:0]    o_a5,
   output logic [OW-1:0]    o_a9,
   output logic [OW-1:0]    o_s7,
   output logic [OW-1:0]    o_c7,
   output logic [OW-1:0]    o_s11,
   output logic [OW-1:0]    o_c11,
   output logic [OW-1:0]    o_s13,
   output logic [OW-1:0]    o_c13,
   output logic [OW-1:0]    o_a16,
   output logic [OW-1:0]    o_na
);

   logic [OW-1:0] w_ax;
   logic [OW-1:0] w_a2;
   logic [OW-1:0] w_a4;
   logic [OW-1:0] w_a8;

   assign w_ax  = {oext(i_a[WIDTH-1], i_signed), i_a};
   assign w_a2  = {w_ax[OW-2:0], 1'b0};
   assign w_a4  = {w_ax[OW-3:0], 2'b0};
   assign w_a8  = {w_ax[OW-4:0], 3'b0};
   assign o_a1  = w_ax;
   // 15A = 16A - A = 16A + ~A + 1; the +1 is the stage-2 carry-in.
   assign o_a16 = {w_ax[OW-5:0], 4'b0};
   assign o_na  = ~w_ax;

   adder #(.W(OW)) u_add3 (.i_a(w_ax), .i_b(w_a2), .i_cin(1'b0), .o_s(o_a3));
   adder #(.W(OW)) u_add5 (.i_a(w_ax), .i_b(w_a4), .i_cin(1'b0), .o_s(o_a5));
   adder #(.W(OW)) u_add9 (.i_a(w_ax), .i_b(w_a8), .i_cin(1'b0), .o_s(o_a9));

   adder_CSA #(.W(OW)) u_csa7  (.i_a(w_ax), .i_b(w_a2), .i_c(w_a4), .o_s(o_s7),  .o_c(o_c7));
   adder_CSA #(.W(OW)) u_csa11 (.i_a(w_ax), .i_b(w_a2), .i_c(w_a8), .o_s(o_s11), .o_c(o_c11));
   adder_CSA #(.W(OW)) u_csa13 (.i_a(w_ax), .i_b(w_a4), .i_c(w_a8), .o_s(o_s13), .o_c(o_c13));

endmodule

// File: rtl/smult_oddtab_pipe.sv
// Two-stage pipelined odd-multiple table (1A..15A) with valid/ready, flush and tag.
module smult_oddtab_pipe import smult_pkg::*; #(
   parameter  int unsigned WIDTH = 65,
   parameter  int unsigned TAG_W = 6,
   localparam int unsigned OW    = WIDTH + EXT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_A,
   input  logic             in_signed,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [TAG_W-1:0] out_tag,
   output logic [OW-1:0]    out_A1,
   output logic [OW-1:0]    out_A3,
   output logic [OW-1:0]    out_A5,
   output logic [OW-1:0]    out_A7,
   output logic [OW-1:0]    out_A9,
   output logic [OW-1:0]    out_A11,
   output logic [OW-1:0]    out_A13,
   output logic [OW-1:0]    out_A15
);

   logic [OW-1:0] w_a1, w_a3, w_a5, w_a9;
   logic [OW-1:0] w_s7, w_c7, w_s11, w_c11, w_s13, w_c13, w_a16, w_na;
   logic [OW-1:0] w_a7, w_a11, w_a13, w_a15;
   logic          w_s1_adv, w_s2_adv, w_acc;

   logic             r_s1_vld;
   logic [TAG_W-1:0] r_s1_tag;
   logic [OW-1:0]    r_s1_a1, r_s1_a3, r_s1_a5, r_s1_a9;
   logic [OW-1:0]    r_s1_s7, r_s1_c7, r_s1_s11, r_s1_c11, r_s1_s13, r_s1_c13;
   logic [OW-1:0]    r_s1_a16, r_s1_na;

   logic             r_s2_vld;
   logic [TAG_W-1:0] r_s2_tag;
   logic [OW-1:0]    r_s2_a1, r_s2_a3, r_s2_a5, r_s2_a7;
   logic [OW-1:0]    r_s2_a9, r_s2_a11, r_s2_a13, r_s2_a15;

   // One-level ready chain: a stage advances when empty or when downstream advances.
   assign w_s2_adv = !r_s2_vld || out_rdy;
   assign w_s1_adv = !r_s1_vld || w_s2_adv;
   assign in_rdy   = w_s1_adv;
   assign w_acc    = in_vld && w_s1_adv;

   smult_oddtab_s1 #(.WIDTH(WIDTH)) u_s1 (
      .i_a     (in_A),
      .i_signed(in_signed),
      .o_a1    (w_a1),
      .o_a3    (w_a3),
      .o_a5    (w_a5),
      .o_a9    (w_a9),
      .o_s7    (w_s7),
      .o_c7    (w_c7),
      .o_s11   (w_s11),
      .o_c11   (w_c11),
      .o_s13   (w_s13),
      .o_c13   (w_c13),
      .o_a16   (w_a16),
      .o_na    (w_na)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_tag <= '0;
         r_s1_a1  <= '0;
         r_s1_a3  <= '0;
         r_s1_a5  <= '0;
         r_s1_a9  <= '0;
         r_s1_s7  <= '0;
         r_s1_c7  <= '0;
         r_s1_s11 <= '0;
         r_s1_c11 <= '0;
         r_s1_s13 <= '0;
         r_s1_c13 <= '0;
         r_s1_a16 <= '0;
         r_s1_na  <= '0;
      end else begin
         if (flush)         r_s1_vld <= 1'b0;
         else if (w_s1_adv) r_s1_vld <= in_vld;
         if (w_acc && !flush) begin
            r_s1_tag <= in_tag;
            r_s1_a1  <= w_a1;
            r_s1_a3  <= w_a3;
            r_s1_a5  <= w_a5;
            r_s1_a9  <= w_a9;
            r_s1_s7  <= w_s7;
            r_s1_c7  <= w_c7;
            r_s1_s11 <= w_s11;
            r_s1_c11 <= w_c11;
            r_s1_s13 <= w_s13;
            r_s1_c13 <= w_c13;
            r_s1_a16 <= w_a16;
            r_s1_na  <= w_na;
         end
      end
   end

   adder #(.W(OW)) u_add7  (.i_a(r_s1_s7),  .i_b(r_s1_c7),  .i_cin(1'b0), .o_s(w_a7));
   adder #(.W(OW)) u_add11 (.i_a(r_s1_s11), .i_b(r_s1_c11), .i_cin(1'b0), .o_s(w_a11));
   adder #(.W(OW)) u_add13 (.i_a(r_s1_s13), .i_b(r_s1_c13), .i_cin(1'b0), .o_s(w_a13));
   adder #(.W(OW)) u_add15 (.i_a(r_s1_a16), .i_b(r_s1_na),  .i_cin(1'b1), .o_s(w_a15));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_s2_tag <= '0;
         r_s2_a1  <= '0;
         r_s2_a3  <= '0;
         r_s2_a5  <= '0;
         r_s2_a7  <= '0;
         r_s2_a9  <= '0;
         r_s2_a11 <= '0;
         r_s2_a13 <= '0;
         r_s2_a15 <= '0;
      end else begin
         if (flush)         r_s2_vld <= 1'b0;
         else if (w_s2_adv) r_s2_vld <= r_s1_vld;
         if (w_s2_adv && r_s1_vld && !flush) begin
            r_s2_tag <= r_s1_tag;
            r_s2_a1  <= r_s1_a1;
            r_s2_a3  <= r_s1_a3;
            r_s2_a5  <= r_s1_a5;
            r_s2_a7  <= w_a7;
            r_s2_a9  <= r_s1_a9;
            r_s2_a11 <= w_a11;
            r_s2_a13 <= w_a13;
            r_s2_a15 <= w_a15;
         end
      end
   end

   assign out_vld = r_s2_vld;
   assign out_tag = r_s2_tag;
   assign out_A1  = r_s2_a1;
   assign out_A3  = r_s2_a3;
   assign out_A5  = r_s2_a5;
   assign out_A7  = r_s2_a7;
   assign out_A9  = r_s2_a9;
   assign out_A11 = r_s2_a11;
   assign out_A13 = r_s2_a13;
   assign out_A15 = r_s2_a15;

endmodule

// File: tb/tb_smult_oddtab_pipe.sv
// Scoreboard bench for smult_oddtab_pipe at WIDTH=8 with hand-computed odd-multiple tables.
module tb_smult_oddtab_pipe;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned TAG_W = 6;
   localparam int unsigned OW    = WIDTH + 4;

   typedef struct packed {
      logic [WIDTH-1:0]    a;
      logic                sgn;
      logic [7:0][OW-1:0]  m;
   } vec_t;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [7:0][OW-1:0]  m;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_vld = 1'b0;
   logic             in_rdy;
   logic [WIDTH-1:0] in_A = '0;
   logic             in_signed = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_vld;
   logic             out_rdy = 1'b1;
   logic [TAG_W-1:0] out_tag;
   logic [OW-1:0]    out_A1, out_A3, out_A5, out_A7, out_A9, out_A11, out_A13, out_A15;

   vec_t vtab [10];
   exp_t sb [$];
   int   cur_idx = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   smult_oddtab_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_A(in_A), .in_signed(in_signed), .in_tag(in_tag),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_tag(out_tag),
      .out_A1(out_A1), .out_A3(out_A3), .out_A5(out_A5), .out_A7(out_A7),
      .out_A9(out_A9), .out_A11(out_A11), .out_A13(out_A13), .out_A15(out_A15)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] a, input logic sgn,
                               input logic [11:0] e1, input logic [11:0] e3,
                               input logic [11:0] e5, input logic [11:0] e7,
                               input logic [11:0] e9, input logic [11:0] e11,
                               input logic [11:0] e13, input logic [11:0] e15);
      vec_t v;
      v.a = a; v.sgn = sgn;
      v.m[0] = e1; v.m[1] = e3; v.m[2] = e5;  v.m[3] = e7;
      v.m[4] = e9; v.m[5] = e11; v.m[6] = e13; v.m[7] = e15;
      return v;
   endfunction

   // Issue side: record the expected table for every accepted operand.
   always @(posedge clk) begin
      exp_t e;
      if (flush) sb.delete();
      else if (!rst && in_vld && in_rdy) begin
         e.tag = in_tag;
         e.m   = vtab[cur_idx].m;
         sb.push_back(e);
      end
   end

   // Monitor: every presented table is compared to the queue head; popped on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_vld) begin
         if (sb.size() == 0) chk("spurious_out_vld", {15'd0, out_vld}, 16'd0);
         else begin
            e = sb[0];
            chk("out_tag", {10'd0, out_tag}, {10'd0, e.tag});
            chk("out_A1",  {4'd0, out_A1},  {4'd0, e.m[0]});
            chk("out_A3",  {4'd0, out_A3},  {4'd0, e.m[1]});
            chk("out_A5",  {4'd0, out_A5},  {4'd0, e.m[2]});
            chk("out_A7",  {4'd0, out_A7},  {4'd0, e.m[3]});
            chk("out_A9",  {4'd0, out_A9},  {4'd0, e.m[4]});
            chk("out_A11", {4'd0, out_A11}, {4'd0, e.m[5]});
            chk("out_A13", {4'd0, out_A13}, {4'd0, e.m[6]});
            chk("out_A15", {4'd0, out_A15}, {4'd0, e.m[7]});
            if (out_rdy) void'(sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx, input logic [TAG_W-1:0] tag);
      cur_idx   = idx;
      in_A      = vtab[idx].a;
      in_signed = vtab[idx].sgn;
      in_tag    = tag;
      in_vld    = 1'b1;
   endtask

   task automatic drain();
      int unsigned n = 0;
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      while ((sb.size() != 0 || out_vld) && n < 50) begin
         tick();
         n++;
      end
      chk("drain_bound", {15'd0, n < 50}, 16'd1);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_vld"}, {15'd0, out_vld}, 16'd0);
      chk({tag, "_tag"}, {10'd0, out_tag}, 16'd0);
      chk({tag, "_A1"},  {4'd0, out_A1},  16'd0);
      chk({tag, "_A7"},  {4'd0, out_A7},  16'd0);
      chk({tag, "_A13"}, {4'd0, out_A13}, 16'd0);
      chk({tag, "_A15"}, {4'd0, out_A15}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      n_bad++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vtab[0] = mk(8'hFF, 1'b0, 12'h0FF, 12'h2FD, 12'h4FB, 12'h6F9, 12'h8F7, 12'hAF5, 12'hCF3, 12'hEF1);
      vtab[1] = mk(8'h80, 1'b1, 12'hF80, 12'hE80, 12'hD80, 12'hC80, 12'hB80, 12'hA80, 12'h980, 12'h880);
      vtab[2] = mk(8'h01, 1'b0, 12'h001, 12'h003, 12'h005, 12'h007, 12'h009, 12'h00B, 12'h00D, 12'h00F);
      vtab[3] = mk(8'h02, 1'b0, 12'h002, 12'h006, 12'h00A, 12'h00E, 12'h012, 12'h016, 12'h01A, 12'h01E);
      vtab[4] = mk(8'h03, 1'b0, 12'h003, 12'h009, 12'h00F, 12'h015, 12'h01B, 12'h021, 12'h027, 12'h02D);
      vtab[5] = mk(8'hFF, 1'b1, 12'hFFF, 12'hFFD, 12'hFFB, 12'hFF9, 12'hFF7, 12'hFF5, 12'hFF3, 12'hFF1);
      vtab[6] = mk(8'h7F, 1'b1, 12'h07F, 12'h17D, 12'h27B, 12'h379, 12'h477, 12'h575, 12'h673, 12'h771);
      vtab[7] = mk(8'h80, 1'b0, 12'h080, 12'h180, 12'h280, 12'h380, 12'h480, 12'h580, 12'h680, 12'h780);
      vtab[8] = mk(8'h00, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
      vtab[9] = mk(8'h55, 1'b1, 12'h055, 12'h0FF, 12'h1A9, 12'h253, 12'h2FD, 12'h3A7, 12'h451, 12'h4FB);

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk_zero_outputs("reset");
      chk("reset_in_rdy", {15'd0, in_rdy}, 16'd1);
      tick();
      tick();
      rst = 1'b0;

      // Latency with an idle pipe: unsigned 0xFF
      drive(0, 6'd5);
      tick();
      in_vld = 1'b0;
      chk("lat_cycle1_vld", {15'd0, out_vld}, 16'd0);
      tick();
      chk("lat_cycle2_vld", {15'd0, out_vld}, 16'd1);
      tick();
      chk("lat_single_pulse", {15'd0, out_vld}, 16'd0);

      // Signed most-negative operand
      drive(1, 6'd6);
      tick();
      drain();

      // Back-to-back 1,2,3 -> three consecutive valid cycles
      drive(2, 6'd1);
      tick();
      drive(3, 6'd2);
      tick();
      chk("b2b_vld0", {15'd0, out_vld}, 16'd1);
      drive(4, 6'd3);
      tick();
      chk("b2b_vld1", {15'd0, out_vld}, 16'd1);
      in_vld = 1'b0;
      tick();
      chk("b2b_vld2", {15'd0, out_vld}, 16'd1);
      tick();
      chk("b2b_end", {15'd0, out_vld}, 16'd0);
      drain();

      // Backpressure: 3 offered, 2 accepted, outputs hold
      out_rdy = 1'b0;
      drive(5, 6'd10);
      tick();
      drive(6, 6'd11);
      tick();
      drive(7, 6'd12);
      chk("bp_in_rdy_low", {15'd0, in_rdy}, 16'd0);
      tick();
      tick();
      tick();
      chk("bp_in_rdy_still_low", {15'd0, in_rdy}, 16'd0);
      chk("bp_accepted", sb.size()[15:0], 16'd2);
      chk("bp_held_tag", {10'd0, out_tag}, 16'd10);
      out_rdy = 1'b1;
      tick();
      in_vld = 1'b0;
      drain();

      // Flush a full pipe while an operand is offered with in_rdy high
      out_rdy = 1'b0;
      drive(8, 6'd20);
      tick();
      drive(9, 6'd21);
      tick();
      drive(2, 6'd22);
      out_rdy = 1'b1;
      flush   = 1'b1;
      #1;
      chk("flush_in_rdy", {15'd0, in_rdy}, 16'd1);
      tick();
      flush  = 1'b0;
      in_vld = 1'b0;
      chk("flush_vld_cleared", {15'd0, out_vld}, 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flush_no_entries", {15'd0, out_vld}, 16'd0);
      end

      // Asynchronous reset between edges with the pipe full
      out_rdy = 1'b0;
      drive(0, 6'd40);
      tick();
      drive(1, 6'd41);
      tick();
      in_vld = 1'b0;
      chk("pre_rst_full", {15'd0, out_vld}, 16'd1);
      #3 rst = 1'b1;
      #1;
      sb.delete();
      chk_zero_outputs("async_rst");
      tick();
      rst = 1'b0;
      chk("post_rst_in_rdy", {15'd0, in_rdy}, 16'd1);
      chk("post_rst_vld", {15'd0, out_vld}, 16'd0);
      out_rdy = 1'b1;
      drive(9, 6'd30);
      tick();
      drain();

      // Mixed signed/unsigned back-to-back with intermittent stall
      drive(0, 6'd50);
      tick();
      drive(5, 6'd51);
      tick();
      out_rdy = 1'b0;
      drive(7, 6'd52);
      tick();
      out_rdy = 1'b1;
      tick();
      drive(1, 6'd53);
      tick();
      drive(6, 6'd54);
      tick();
      drain();

      chk("scoreboard_empty", sb.size()[15:0], 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
